// File: rtl/tc_split_pkg.sv
// Shared definitions for the stream splitter family.
//   state_e         : two-state control FSM encoding (StIdle, StEmit)
//   tc_norm_count() : maps a requested lane count onto 1..lanes
//                     (0 or anything above lanes selects the full word)
package tc_split_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StEmit = 1'b1
  } state_e;

  function automatic int unsigned tc_norm_count(input int unsigned count,
                                                input int unsigned lanes);
    return ((count == 0) || (count > lanes)) ? lanes : count;
  endfunction

endpackage

// File: rtl/tc_lane_mux.sv
// Combinational lane selector: returns lane i_sel of i_word, where lane k is
// i_word[k*LANE_WIDTH +: LANE_WIDTH]. Out-of-range selects return zero.
//   i_word : IN_WIDTH-bit source word
//   i_sel  : lane number
//   o_lane : selected LANE_WIDTH-bit lane
module tc_lane_mux #(
  parameter int unsigned IN_WIDTH   = 64,
  parameter int unsigned LANE_WIDTH = 8,
  localparam int unsigned LANES     = IN_WIDTH / LANE_WIDTH,
  localparam int unsigned IDX_W     = $clog2(LANES)
) (
  input  logic [IN_WIDTH-1:0]   i_word,
  input  logic [IDX_W-1:0]      i_sel,
  output logic [LANE_WIDTH-1:0] o_lane
);

  always_comb begin
    o_lane = '0;
    for (int k = 0; k < LANES; k++) begin
      if (i_sel == IDX_W'(k)) begin
        o_lane = i_word[k*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

endmodule

// File: rtl/tc_splitter_stream.sv
// Wide-to-narrow stream splitter. Takes one IN_WIDTH word via valid/ready and
// emits N of its lanes, one per handshake, in LSB-first or MSB-first order.
//   clk, rst_n                        : clock, async active-low reset
//   in_valid/in_ready                 : input word handshake
//   in_data, in_count, in_msb_first   : word, lane count (0/>LANES = all), order
//   out_valid/out_ready               : output lane handshake
//   out_data, out_index, out_last     : lane, its original lane number, final flag
//   busy                              : a word is held (same as out_valid)
module tc_splitter_stream
  import tc_split_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = 64,
  parameter int unsigned LANE_WIDTH = 8,
  localparam int unsigned LANES     = IN_WIDTH / LANE_WIDTH,
  localparam int unsigned CNT_W     = $clog2(LANES + 1),
  localparam int unsigned IDX_W     = $clog2(LANES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_data,
  input  logic [CNT_W-1:0]      in_count,
  input  logic                  in_msb_first,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANE_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]      out_index,
  output logic                  out_last,
  output logic                  busy
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [IN_WIDTH-1:0]   r_word;
  logic [IDX_W-1:0]      r_idx;
  logic [CNT_W-1:0]      r_rem;
  logic                  r_msb;

  logic                  w_emit;
  logic                  w_last;
  logic                  w_take;
  logic                  w_accept;
  logic [LANE_WIDTH-1:0] w_lane;

  assign w_emit   = (r_state == StEmit);
  assign w_last   = (r_rem == CNT_W'(1));
  assign w_take   = w_emit && out_ready;
  // A new word may land in the same cycle the last lane leaves, so in_ready
  // depends combinationally on out_ready.
  assign w_accept = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: if (w_accept) w_state_nxt = StEmit;
      StEmit: if (w_take && w_last) w_state_nxt = w_accept ? StEmit : StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Held word, lane pointer and remaining count. The word is never shifted;
  // r_idx walks up (LSB order) or down (MSB order) and never wraps since
  // r_rem stops it at the Nth lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_idx  <= '0;
      r_rem  <= '0;
      r_msb  <= 1'b0;
    end else if (w_accept) begin
      r_word <= in_data;
      r_rem  <= CNT_W'(tc_norm_count(32'(in_count), LANES));
      r_msb  <= in_msb_first;
      r_idx  <= in_msb_first ? IDX_W'(LANES - 1) : '0;
    end else if (w_take && !w_last) begin
      r_rem  <= r_rem - CNT_W'(1);
      r_idx  <= r_msb ? (r_idx - IDX_W'(1)) : (r_idx + IDX_W'(1));
    end
  end

  tc_lane_mux #(
    .IN_WIDTH  (IN_WIDTH),
    .LANE_WIDTH(LANE_WIDTH)
  ) u_lane_mux (
    .i_word(r_word),
    .i_sel (r_idx),
    .o_lane(w_lane)
  );

  // Outputs, forced to zero while idle
  always_comb begin
    out_valid = w_emit;
    busy      = w_emit;
    out_data  = w_emit ? w_lane : '0;
    out_index = w_emit ? r_idx : '0;
    out_last  = w_emit && w_last;
    in_ready  = !w_emit || (out_ready && w_last);
  end

endmodule

// File: tb/tb_tc_splitter_stream.sv
module tb_tc_splitter_stream;

  localparam int unsigned IN_WIDTH   = 64;
  localparam int unsigned LANE_WIDTH = 8;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned IDX_W      = 3;

  localparam logic [63:0] WORD_A = 64'h8877665544332211;
  localparam logic [63:0] WORD_B = 64'hF0E0D0C0B0A09080;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_WIDTH-1:0]   in_data;
  logic [CNT_W-1:0]      in_count;
  logic                  in_msb_first;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANE_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]      out_index;
  logic                  out_last;
  logic                  busy;

  int compared;
  int mismatched;

  tc_splitter_stream #(
    .IN_WIDTH  (IN_WIDTH),
    .LANE_WIDTH(LANE_WIDTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_count    (in_count),
    .in_msb_first(in_msb_first),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_last    (out_last),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check a presented lane: data, index, last flag, valid and busy.
  task automatic chk_lane(input string tag, input logic [7:0] d, input int idx,
                          input logic last);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".busy"},  64'(busy),      64'd1);
    chk({tag, ".data"},  64'(out_data),  64'(d));
    chk({tag, ".index"}, 64'(out_index), 64'(idx));
    chk({tag, ".last"},  64'(out_last),  64'(last));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".busy"},  64'(busy),      64'd0);
    chk({tag, ".ready"}, 64'(in_ready),  64'd1);
  endtask

  // Offer a word at a negedge; it is taken at the following posedge.
  task automatic offer(input logic [63:0] d, input logic [3:0] cnt, input logic msb);
    in_valid     = 1'b1;
    in_data      = d;
    in_count     = cnt;
    in_msb_first = msb;
    #1;
    chk("offer.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int k;
    logic [3:0] pat;
    compared     = 0;
    mismatched   = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_count     = '0;
    in_msb_first = 1'b0;
    out_ready    = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_data",  64'(out_data),  64'd0);
    chk("rst.out_index", 64'(out_index), 64'd0);
    chk("rst.out_last",  64'(out_last),  64'd0);
    chk("rst.busy",      64'(busy),      64'd0);
    #2 rst_n = 1'b1;
    #1 chk("rst.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // LSB order, count 0 (= all 8 lanes), out_ready held high
    out_ready = 1'b1;
    offer(WORD_A, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk_lane("lsb8", 8'(8'h11 * (i + 1)), i, i == 7);
      @(negedge clk);
    end
    chk_idle("lsb8.end");

    // MSB order, count 3: lanes 7,6,5
    offer(WORD_A, 4'd3, 1'b1);
    chk_lane("msb3.0", 8'h88, 7, 1'b0);
    @(negedge clk);
    chk_lane("msb3.1", 8'h77, 6, 1'b0);
    @(negedge clk);
    chk_lane("msb3.2", 8'h66, 5, 1'b1);
    @(negedge clk);
    chk_idle("msb3.end");

    // Backpressure: out_ready pattern 1,0,0,1 repeating, count 4 LSB
    offer(WORD_A, 4'd4, 1'b0);
    pat = 4'b1001;
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      out_ready = pat[3 - (c % 4)];
      #1;
      chk_lane("bp", 8'(8'h11 * (k + 1)), k, k == 3);
      chk("bp.in_ready", 64'(in_ready), 64'(out_ready && (k == 3)));
      if (out_ready) k++;
      @(negedge clk);
    end
    chk("bp.lanes_taken", 64'(k), 64'd4);
    out_ready = 1'b1;
    #1 chk_idle("bp.end");

    // Back-to-back: word B offered from lane 5 onward, accepted on lane 7
    offer(WORD_A, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i >= 5) begin
        in_valid     = 1'b1;
        in_data      = WORD_B;
        in_count     = 4'd8;
        in_msb_first = 1'b0;
      end
      #1;
      chk_lane("b2b.a", 8'(8'h11 * (i + 1)), i, i == 7);
      chk("b2b.in_ready", 64'(in_ready), 64'(i == 7));
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_lane("b2b.b", 8'(8'h80 + 8'h10 * i), i, i == 7);
      @(negedge clk);
    end
    chk_idle("b2b.end");

    // Count 1 in MSB order: only lane 7
    offer(WORD_A, 4'd1, 1'b1);
    chk_lane("n1", 8'h88, 7, 1'b1);
    @(negedge clk);
    chk_idle("n1.end");

    // Count 9 behaves as 8
    offer(WORD_B, 4'd9, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk_lane("n9", 8'(8'h80 + 8'h10 * i), i, i == 7);
      @(negedge clk);
    end
    chk_idle("n9.end");

    // Asynchronous reset mid-word
    offer(WORD_A, 4'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk_lane("arst.pre", 8'h33, 2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 64'(out_valid), 64'd0);
    chk("arst.busy",      64'(busy),      64'd0);
    chk("arst.out_data",  64'(out_data),  64'd0);
    chk("arst.out_index", 64'(out_index), 64'd0);
    #1 rst_n = 1'b1;
    #1 chk("arst.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk_idle("arst.idle");
    offer(WORD_B, 4'd2, 1'b0);
    chk_lane("arst.new0", 8'h80, 0, 1'b0);
    @(negedge clk);
    chk_lane("arst.new1", 8'h90, 1, 1'b1);
    @(negedge clk);
    chk_idle("arst.end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tc_splitter_stream.md
Name: tc_splitter_stream

Overview:
Parametrised, sequential successor to the fixed 64-to-8x8 combinational splitter. It accepts one wide word through a valid/ready handshake and emits the word's lanes one per cycle on a narrow valid/ready output. Lane order is selectable per word, and a per-word lane count allows partial emission. It sits between wide datapath producers (e.g. the 32x32 multiplier's 64-bit product) and byte-wide consumers such as an output port, RAM write path or display.

Parameters:
IN_WIDTH, 64, width of input word; must be a multiple of LANE_WIDTH.
LANE_WIDTH, 8, width of each emitted lane.
LANES, IN_WIDTH/LANE_WIDTH (derived, localparam), lanes per word; must be >= 2.
CNT_W, $clog2(LANES+1) (derived), width of the count field.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word offered
in_ready  output  1  block can take a word this cycle
in_data  input  IN_WIDTH  word; lane k = in_data[k*LANE_WIDTH +: LANE_WIDTH]
in_count  input  CNT_W  lanes to emit; 0 or any value > LANES means LANES
in_msb_first  input  1  1: emit lanes from the top lane down; 0: from lane 0 up
out_valid  output  1  lane presented
out_ready  input  1  consumer takes lane
out_data  output  LANE_WIDTH  current lane
out_index  output  $clog2(LANES)  lane number k of out_data within the original word
out_last  output  1  final lane of the current word
busy  output  1  word held (equals out_valid)

Behaviour:
- Clock and reset are fixed: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- Reset, asserted at any time including mid-word: state goes to IDLE and the held word is discarded. Outputs: out_valid=0, out_data=0, out_index=0, out_last=0, busy=0. in_ready=1 once rst_n is high.
- State machine has two states, IDLE and EMIT.
  - IDLE: in_ready=1 and out_valid=0. On in_valid, capture in_data, the effective count N, and the order; go to EMIT.
  - EMIT: out_valid=1. The lane sequence is:
    - LSB order: lanes 0,1,...,N-1.
    - MSB order: lanes LANES-1, LANES-2, ..., LANES-N.
  - out_index always gives the original lane number k, not the position in the sequence.
  - A lane advances only on out_valid && out_ready. out_data, out_index and out_last are stable while out_ready=0.
  - out_last=1 exactly on the Nth lane.
- Latency: the first lane appears the cycle after the input handshake, so input-to-first-output latency is 1 cycle.
- Back-to-back words: in_ready = IDLE || (out_valid && out_last && out_ready). This is a combinational path from out_ready.
  - If a new word is accepted in the same cycle the last lane is taken, the block stays in EMIT and the new word's first lane appears the next cycle.
  - Sustained throughput is therefore N lanes per N cycles, with no bubble between words.
  - If no new word is offered, the block returns to IDLE.
- Edge cases:
  - N=1: a single lane with out_last=1. The lane is lane 0 in LSB order, lane LANES-1 in MSB order.
  - in_valid while in EMIT and not on the last handshake: not accepted (in_ready=0). The producer must hold its word.
  - out_ready held high throughout: one lane per cycle.
- Datapath:
  - Lanes are selected from a registered copy of the word using a lane index counter. The word is not shifted.
  - The counter increments in LSB order and decrements in MSB order. It never wraps within a word.
  - A separate remaining-count register reaches 1 on the last lane.

Decomposition:
- Shared package tc_split_pkg holds:
  - the state enum (IDLE, EMIT);
  - the count-normalisation rule (0 or > LANES maps to LANES), as a function.
- One natural sub-module: tc_lane_mux, a combinational selection of lane k from the word, parametrised by IN_WIDTH and LANE_WIDTH. It is reusable by later joiner/merger blocks.

Test Plan:
- Reset then LSB order, count 0, in_data=64'h8877665544332211, out_ready=1:
  - outputs 11,22,...,88 on consecutive cycles;
  - out_index 0..7;
  - out_last only with 88;
  - then in_ready=1 and busy=0.
- MSB order, count 3, same data: outputs 88,77,66 with out_index 7,6,5 and out_last with 66; no further lanes.
- Backpressure: out_ready toggles 1,0,0,1,... during a word. Each lane is held stable while out_ready=0, no lane is duplicated or dropped, and in_ready=0 until the final handshake.
- Back-to-back: a second word (64'hF0E0D0C0B0A09080, LSB, count 8) is offered during the first word's last lane. It is accepted that cycle, and 80 follows 88 with no idle cycle.
- Count 1 and count 9: count 1 in MSB order gives lane 7 only, with out_last=1. Count 9 is treated as 8.
- rst_n pulsed low mid-word, between clock edges: out_valid drops immediately (asynchronously). After release, in_ready=1 and the next accepted word starts from its first lane.
